instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage feeding the multi-cycle control unit.
- Owns the program counter (PC) and instruction register (IR), and runs a req/ack handshake to instruction memory with a timeout.
- Exposes the decoded opcode and register/immediate select (op_type, reg_imm) taken from the latched instruction.
- The control unit starts a fetch with a one-cycle fetch_start pulse, taken from its FETCH-state pc_en/ir_en. It loads branch targets through pc_write/pc_load_val.

Parameters:
- ADDR_W, 8, PC and memory address width.
- DATA_W, 16, instruction width (must be >= 12).
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, maximum REQ cycles without ack before abort (>= 1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_start  in  1  one-cycle request to fetch the instruction at PC.
- pc_write  in  1  load PC from pc_load_val.
- pc_load_val  in  ADDR_W  branch/jump target.
- imem_req  out  1  memory request, registered.
- imem_addr  out  ADDR_W  memory address, equal to pc while imem_req=1.
- imem_rdata  in  DATA_W  memory read data, valid when imem_ack=1.
- imem_ack  in  1  memory acknowledge.
- pc  out  ADDR_W  current PC.
- instr  out  DATA_W  instruction register.
- op_type  out  4  instr[DATA_W-1:DATA_W-4], combinational from IR.
- reg_imm  out  1  instr[DATA_W-5], combinational from IR.
- fetch_busy  out  1  high in REQ state.
- fetch_done  out  1  one-cycle pulse: IR updated.
- fetch_err  out  1  one-cycle pulse: timeout abort.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - State goes to IDLE; pc=RESET_PC; instr=0, so op_type=0 and reg_imm=0.
  - imem_req, fetch_busy, fetch_done, fetch_err, timeout counter and pending-load flag all clear to 0.
  - Reset mid-REQ drops imem_req immediately. An ack arriving during or after reset is ignored.
- States: IDLE, REQ.
- IDLE:
  - fetch_start=1 -> REQ next cycle. imem_req=1 with imem_addr=pc from that cycle on.
  - pc_write=1 -> pc<=pc_load_val.
  - pc_write and fetch_start in the same cycle: both act. The fetch uses the new PC because the address is driven from the pc register in REQ.
- REQ:
  - imem_req stays 1 and imem_addr is held stable until ack or timeout.
  - The counter increments each REQ cycle in which imem_ack=0.
  - imem_ack=1 sampled at an edge:
    - instr<=imem_rdata.
    - pc<=pc+1 (modulo 2^ADDR_W, so all-ones wraps to 0), or pc<=pending target if a load is pending.
    - fetch_done=1 for the next cycle.
    - State goes to IDLE and imem_req goes to 0 at that same edge.
  - Minimum latency: fetch_start at edge N, req high in cycle N+1, ack in cycle N+1 sampled at edge N+2, fetch_done high in cycle N+2.
  - Timeout: the counter reaches TIMEOUT with no ack.
    - imem_req drops and the state returns to IDLE.
    - fetch_err pulses for 1 cycle.
    - instr and pc are unchanged, except that a pending load is applied.
  - Ack has priority over timeout on the same edge.
  - The counter clears on entry to REQ.
- pc_write while in REQ:
  - Captured into a pending register; the latest write wins.
  - The current fetch still completes from the old address.
  - At completion or timeout, pc takes the pending value instead of incrementing, and the flag clears.
- fetch_start while in REQ: ignored, no queueing.
- imem_ack while in IDLE: ignored, no state change.
- fetch_done and fetch_err are never high in the same cycle.

Test Plan:
- Reset then idle:
  - Stimulus: RESET_PC=0, rst_n low then high.
  - Required response: pc=0, instr=0, imem_req=0. All pulses stay low for 10 cycles with no stimulus.
- Basic fetch:
  - Stimulus: fetch_start at pc=0x05; memory acks 3 cycles after req with rdata=0x9A34.
  - Required response: imem_addr=0x05 held for all req cycles; instr=0x9A34; op_type=9; reg_imm=1; pc=0x06; fetch_done pulses exactly one cycle.
- Branch load:
  - Stimulus: pc_write with pc_load_val=0x40, same cycle as fetch_start.
  - Required response: imem_addr=0x40; after ack, pc=0x41.
  - Stimulus: pc_write=0x20 during REQ at addr 0x10.
  - Required response: fetch completes from 0x10; pc=0x20, not 0x11.
- Timeout:
  - Stimulus: TIMEOUT=15, no ack.
  - Required response: imem_req drops after 15 REQ cycles; fetch_err pulses once; pc and instr unchanged; a following fetch_start re-requests the same address.
- Wrap and corner cases:
  - pc=0xFF fetch -> pc=0x00.
  - Ack on the exact timeout edge -> fetch_done, no fetch_err.
  - fetch_start during REQ -> ignored.
  - Stray ack in IDLE -> no change.
- Reset mid-fetch:
  - Stimulus: rst_n low while in REQ, then an ack.
  - Required response: imem_req=0 immediately; pc=RESET_PC; the ack has no effect; no pulses.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns PC and IR, runs the req/ack handshake to
// instruction memory with a bounded wait, and exposes opcode fields from IR.
module instr_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_start,
    input  logic              pc_write,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic [3:0]        op_type,
    output logic              reg_imm,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              fetch_err
);

    localparam int                CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              pend_vld;
    logic [ADDR_W-1:0] pend_pc;
    logic [ADDR_W-1:0] pc_p0;
    logic [ADDR_W-1:0] pc_nxt;
    logic [DATA_W-1:0] ir_p1;
    logic              done_p1;
    logic              err_p1;
    logic              ack_hit;
    logic              tmo_hit;
    logic              fetch_end;

    // Sequential PC advance; all-ones wraps to zero naturally.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    always_comb begin
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fetch_start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // Ack wins over a timeout on the same edge.
                ack_hit = imem_ack;
                tmo_hit = !imem_ack && (tmo_cnt == TMO_LAST);
                if (ack_hit || tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fetch_end = ack_hit || tmo_hit;

    // A write landing on the completion edge is the latest, so it beats the pending one.
    always_comb begin
        pc_nxt = pc_p0;
        if (state == IDLE) begin
            if (pc_write) begin
                pc_nxt = pc_load_val;
            end
        end else if (fetch_end) begin
            if (pc_write) begin
                pc_nxt = pc_load_val;
            end else if (pend_vld) begin
                pc_nxt = pend_pc;
            end else if (ack_hit) begin
                pc_nxt = pc_inc(pc_p0);
            end
        end
    end

    // Stage boundary: state, PC, IR and completion pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tmo_cnt  <= '0;
            pend_vld <= 1'b0;
            pc_p0    <= PC_RST;
            ir_p1    <= '0;
            done_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_p0   <= pc_nxt;
            done_p1 <= ack_hit;
            err_p1  <= tmo_hit;
            if (ack_hit) begin
                ir_p1 <= imem_rdata;
            end
            if (state != REQ || fetch_end) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (state != REQ || fetch_end) begin
                pend_vld <= 1'b0;
            end else if (pc_write) begin
                pend_vld <= 1'b1;
            end
        end
    end

    // Branch target parked while a fetch is outstanding; qualified by pend_vld.
    always_ff @(posedge clk) begin
        if (state == REQ && pc_write) begin
            pend_pc <= pc_load_val;
        end
    end

    assign imem_req   = (state == REQ);
    assign fetch_busy = (state == REQ);
    assign imem_addr  = pc_p0;
    assign pc         = pc_p0;
    assign instr      = ir_p1;
    assign op_type    = ir_p1[DATA_W-1 -: 4];
    assign reg_imm    = ir_p1[DATA_W-5];
    assign fetch_done = done_p1;
    assign fetch_err  = err_p1;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: table of fetch transactions plus hand sequences,
// with a scoreboard queue checked on every fetch_done/fetch_err pulse.
module tb_instr_fetch_unit;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              rst_n;
    logic              fetch_start;
    logic              pc_write;
    logic [ADDR_W-1:0] pc_load_val;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_ack;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [3:0]        op_type;
    logic              reg_imm;
    logic              fetch_busy;
    logic              fetch_done;
    logic              fetch_err;

    instr_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(0),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_start(fetch_start),
        .pc_write   (pc_write),
        .pc_load_val(pc_load_val),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .pc         (pc),
        .instr      (instr),
        .op_type    (op_type),
        .reg_imm    (reg_imm),
        .fetch_busy (fetch_busy),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    typedef struct {
        logic        preload;
        logic [7:0]  start_pc;
        logic        wr_same;
        logic [7:0]  wr_val;
        logic        wr_req;
        logic [7:0]  req_val;
        logic [15:0] rdata;
        int          ack_dly;
        logic [7:0]  exp_addr;
        logic        exp_err;
        logic [7:0]  exp_pc;
        logic [15:0] exp_instr;
        int          exp_cycles;
    } vec_t;

    typedef struct {
        logic        err;
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[9];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (fetch_done || fetch_err)) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", {30'd0, fetch_done, fetch_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("fetch_err", fetch_err, mon_e.err);
                chk("fetch_done", fetch_done, !mon_e.err);
                chk("pc", pc, mon_e.pc);
                chk("instr", instr, mon_e.instr);
                chk("op_type", op_type, mon_e.instr[15:12]);
                chk("reg_imm", reg_imm, mon_e.instr[11]);
            end
        end
    end

    task automatic do_fetch(input vec_t v);
        int   k;
        logic held;
        exp_t e;
        if (v.preload) begin
            @(negedge clk);
            pc_write    = 1'b1;
            pc_load_val = v.start_pc;
        end
        @(negedge clk);
        fetch_start = 1'b1;
        pc_write    = v.wr_same;
        pc_load_val = v.wr_val;
        e.err   = v.exp_err;
        e.pc    = v.exp_pc;
        e.instr = v.exp_instr;
        sb.push_back(e);
        @(negedge clk);
        fetch_start = 1'b0;
        pc_write    = 1'b0;
        k    = 0;
        held = 1'b1;
        while (imem_req === 1'b1 && k < TIMEOUT + 4) begin
            k++;
            if (imem_addr !== v.exp_addr) held = 1'b0;
            imem_ack    = (k == v.ack_dly + 1);
            imem_rdata  = imem_ack ? v.rdata : 16'hDEAD;
            pc_write    = v.wr_req && (k == 1);
            pc_load_val = v.req_val;
            fetch_start = (k == 2);
            @(negedge clk);
            imem_ack    = 1'b0;
            pc_write    = 1'b0;
            fetch_start = 1'b0;
        end
        chk("req_cycles", k, v.exp_cycles);
        chk("addr_held", held, 1'b1);
        @(negedge clk);
        chk("pulse_width", {30'd0, fetch_done, fetch_err}, 32'd0);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int bad;
        rst_n       = 1'b0;
        fetch_start = 1'b0;
        pc_write    = 1'b0;
        pc_load_val = '0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;

        //         pre start  same wval   wreq rval   rdata     dly  addr   err  pc     instr     cyc
        vecs[0] = '{1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 8'h00, 16'h9A34, 3,  8'h05, 1'b0, 8'h06, 16'h9A34, 4};
        vecs[1] = '{1'b1, 8'h05, 1'b1, 8'h40, 1'b0, 8'h00, 16'h1234, 0,  8'h40, 1'b0, 8'h41, 16'h1234, 1};
        vecs[2] = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 8'h20, 16'h5678, 2,  8'h10, 1'b0, 8'h20, 16'h5678, 3};
        vecs[3] = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 16'hF00F, 1,  8'hFF, 1'b0, 8'h00, 16'hF00F, 2};
        vecs[4] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 8'h00, 16'h0C01, 14, 8'h33, 1'b0, 8'h34, 16'h0C01, 15};
        vecs[5] = '{1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00, 16'hABCD, 99, 8'h77, 1'b1, 8'h77, 16'h0C01, 15};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1111, 0,  8'h77, 1'b0, 8'h78, 16'h1111, 1};
        vecs[7] = '{1'b1, 8'h50, 1'b0, 8'h00, 1'b1, 8'h60, 16'h2222, 99, 8'h50, 1'b1, 8'h60, 16'h1111, 15};
        vecs[8] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 16'h7FFF, 0,  8'h00, 1'b0, 8'h01, 16'h7FFF, 1};

        // Reset state, then ten idle cycles
        repeat (3) @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_busy", fetch_busy, 1'b0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_op", {op_type, reg_imm}, 5'd0);
        chk("rst_pulses", {fetch_done, fetch_err}, 2'b00);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req || fetch_done || fetch_err || pc !== 8'h00) bad++;
        end
        chk("idle_quiet", bad, 0);

        for (int i = 0; i < 9; i++) begin
            do_fetch(vecs[i]);
        end

        // Stray ack while idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_ack   = 1'b1;
            imem_rdata = 16'hFFFF;
        end
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("stray_pc", pc, 8'h01);
        chk("stray_instr", instr, 16'h7FFF);
        chk("stray_req", imem_req, 1'b0);
        chk("stray_sb", sb.size(), 0);

        // Reset in the middle of a request, with an ack straddling release
        @(negedge clk);
        pc_write    = 1'b1;
        pc_load_val = 8'h22;
        @(negedge clk);
        pc_write    = 1'b0;
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        chk("mid_req_on", imem_req, 1'b1);
        chk("mid_addr", imem_addr, 8'h22);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_req_drop", imem_req, 1'b0);
        chk("mid_busy", fetch_busy, 1'b0);
        chk("mid_pc", pc, 8'h00);
        chk("mid_instr", instr, 16'h0000);
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("post_req", imem_req, 1'b0);
        chk("post_pc", pc, 8'h00);
        chk("post_instr", instr, 16'h0000);
        @(negedge clk);
        chk("post_pulses", {fetch_done, fetch_err}, 2'b00);
        chk("post_sb", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
